// File: rtl/router_psum_accum.sv
// router_psum_accum
// Captures the PE cluster column psums in one cycle, then drains them to the
// psum GLB bank. There are two drain modes:
//   direct     : one write per column at an iteration-indexed address
//   accumulate : a read-modify-write per column; the GLB value is added to the psum
// Every GLB strobe, address and direct-mode data word is registered. In
// accumulate mode the write data is the sum of the GLB read data, which arrives
// in the write-back cycle itself, and the frozen hold register. That sum is
// therefore combinational from registered state and the GLB read port.
module router_psum_accum #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int NUM_COLS          = 3,
  parameter int NUM_ITER          = 3,
  parameter int PSUM_BASE_ADDR    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_BITWIDTH-1:0]     r_data_spad_psum [NUM_COLS-1:0],
  input  logic                         write_psum_ctrl,
  input  logic                         accum_en,
  input  logic                         iter_clr,
  output logic                         read_req_glb_psum,
  output logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb_psum,
  input  logic [DATA_BITWIDTH-1:0]     r_data_glb_psum,
  output logic                         write_en_glb_psum,
  output logic [ADDR_BITWIDTH_GLB-1:0] w_addr_glb_psum,
  output logic [DATA_BITWIDTH-1:0]     w_data_glb_psum,
  output logic                         busy,
  output logic                         done,
  output logic                         req_dropped
);

  localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int ITER_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_COLS - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t                   state;
  logic [COL_W-1:0]         col;
  logic [COL_W-1:0]         col_inc;
  logic [ITER_W-1:0]        iter;
  logic [ITER_W-1:0]        iter_nxt;
  logic [DATA_BITWIDTH-1:0] hold [NUM_COLS-1:0];
  logic [DATA_BITWIDTH-1:0] w_data_q;

  // GLB address = base + offset, truncated to the GLB address width
  function automatic logic [ADDR_BITWIDTH_GLB-1:0] glb_addr(input logic [31:0] offset);
    logic [31:0] full;
    full = 32'(PSUM_BASE_ADDR) + offset;
    return full[ADDR_BITWIDTH_GLB-1:0];
  endfunction

  // Direct-mode offset of column c in iteration it
  function automatic logic [31:0] direct_offset(input logic [ITER_W-1:0] it,
                                                input logic [COL_W-1:0]  c);
    return (32'(it) * 32'(NUM_COLS)) + 32'(c);
  endfunction

  assign col_inc     = col + COL_W'(1);
  assign busy        = (state != IDLE);
  assign req_dropped = write_psum_ctrl & busy;

  // Next iteration index: a clear beats the end-of-direct-pass advance
  always_comb begin
    iter_nxt = iter;
    if (iter_clr) begin
      iter_nxt = {ITER_W{1'b0}};
    end else if ((state == WR) && (col == LAST_COL)) begin
      if (iter == LAST_ITER) begin
        iter_nxt = {ITER_W{1'b0}};
      end else begin
        iter_nxt = iter + ITER_W'(1);
      end
    end else begin
      iter_nxt = iter;
    end
  end

  // Iteration index register
  always_ff @(posedge clk) begin
    if (!reset) begin
      iter <= {ITER_W{1'b0}};
    end else begin
      iter <= iter_nxt;
    end
  end

  // Drain FSM: the state register names the GLB access being presented this cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      col               <= {COL_W{1'b0}};
      read_req_glb_psum <= 1'b0;
      r_addr_glb_psum   <= {ADDR_BITWIDTH_GLB{1'b0}};
      write_en_glb_psum <= 1'b0;
      w_addr_glb_psum   <= {ADDR_BITWIDTH_GLB{1'b0}};
      w_data_q          <= {DATA_BITWIDTH{1'b0}};
      done              <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) begin
        hold[i] <= {DATA_BITWIDTH{1'b0}};
      end
    end else begin
      read_req_glb_psum <= 1'b0;
      r_addr_glb_psum   <= {ADDR_BITWIDTH_GLB{1'b0}};
      write_en_glb_psum <= 1'b0;
      w_addr_glb_psum   <= {ADDR_BITWIDTH_GLB{1'b0}};
      w_data_q          <= {DATA_BITWIDTH{1'b0}};
      done              <= 1'b0;
      case (state)
        IDLE: begin
          if (write_psum_ctrl) begin
            hold <= r_data_spad_psum;
            col  <= {COL_W{1'b0}};
            if (accum_en) begin
              state             <= RD;
              read_req_glb_psum <= 1'b1;
              r_addr_glb_psum   <= glb_addr(32'd0);
            end else begin
              state             <= WR;
              write_en_glb_psum <= 1'b1;
              w_addr_glb_psum   <= glb_addr(direct_offset(iter_nxt, {COL_W{1'b0}}));
              w_data_q          <= r_data_spad_psum[0];
            end
          end else begin
            state <= IDLE;
          end
        end
        WR: begin
          if (col == LAST_COL) begin
            state <= IDLE;
            col   <= {COL_W{1'b0}};
            done  <= 1'b1;
          end else begin
            col               <= col_inc;
            write_en_glb_psum <= 1'b1;
            w_addr_glb_psum   <= glb_addr(direct_offset(iter_nxt, col_inc));
            w_data_q          <= hold[col_inc];
          end
        end
        RD: begin
          state             <= WB;
          write_en_glb_psum <= 1'b1;
          w_addr_glb_psum   <= glb_addr(32'(col));
        end
        WB: begin
          if (col == LAST_COL) begin
            state <= IDLE;
            col   <= {COL_W{1'b0}};
            done  <= 1'b1;
          end else begin
            state             <= RD;
            col               <= col_inc;
            read_req_glb_psum <= 1'b1;
            r_addr_glb_psum   <= glb_addr(32'(col_inc));
          end
        end
        default: begin
          state <= IDLE;
          col   <= {COL_W{1'b0}};
        end
      endcase
    end
  end

  // Write data: accumulated sum during write-back, the registered word otherwise
  always_comb begin
    if (state == WB) begin
      w_data_glb_psum = r_data_glb_psum + hold[col];
    end else begin
      w_data_glb_psum = w_data_q;
    end
  end

endmodule

// File: tb/tb_router_psum_accum.sv
// Self-checking bench for router_psum_accum: table vectors, hand-written
// corner sequences and randomized passes, all checked against a GLB/pass model.
module tb_router_psum_accum;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int NC    = 3;
  localparam int NITER = 3;
  localparam int BASE  = 0;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] spad [NC-1:0];
  logic          write_psum_ctrl;
  logic          accum_en;
  logic          iter_clr;
  logic          read_req;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data_glb = '0;
  logic          write_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          busy;
  logic          done;
  logic          req_dropped;

  always #5 clk = ~clk;

  router_psum_accum #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .NUM_COLS(NC),
    .NUM_ITER(NITER), .PSUM_BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .r_data_spad_psum(spad),
    .write_psum_ctrl(write_psum_ctrl), .accum_en(accum_en), .iter_clr(iter_clr),
    .read_req_glb_psum(read_req), .r_addr_glb_psum(r_addr),
    .r_data_glb_psum(r_data_glb), .write_en_glb_psum(write_en),
    .w_addr_glb_psum(w_addr), .w_data_glb_psum(w_data),
    .busy(busy), .done(done), .req_dropped(req_dropped)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  typedef struct {
    bit                   acc;
    bit                   clr;
    bit                   pre;
    logic [NC-1:0][DW-1:0] pre_v;
    logic [NC-1:0][DW-1:0] ps;
    logic [NC-1:0][AW-1:0] ea;
    logic [NC-1:0][DW-1:0] ed;
  } vec_t;

  logic [DW-1:0] glb     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  acc_t exp_w[$];
  acc_t exp_r[$];
  acc_t obs[$];
  int   exp_done[$];
  int   cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   ref_iter = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   mon_en = 1'b0;
  bit   mon_eb;
  bit   mon_ed;
  acc_t mon_e;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cnt);
    end
  endtask

  // GLB bank model: one-cycle read latency, write on the clock edge
  always @(posedge clk) begin
    cnt <= cnt + 1;
    if (read_req === 1'b1) r_data_glb <= glb[r_addr];
    if (write_en === 1'b1) glb[w_addr] <= w_data;
  end

  // Reference model of one accepted request, issued in the cycle numbered cnt
  task automatic model_request(input bit acc, input logic [NC-1:0][DW-1:0] ps);
    acc_t e;
    int st;
    int a;
    st = cnt + 1;
    if (!acc) begin
      for (int c = 0; c < NC; c++) begin
        a = (BASE + ref_iter * NC + c) % DEPTH;
        e.cyc = st + c; e.addr = AW'(a); e.data = ps[c];
        exp_w.push_back(e);
      end
      exp_done.push_back(st + NC);
      busy_lo = st; busy_hi = st + NC - 1;
      ref_iter = (ref_iter + 1) % NITER;
    end else begin
      for (int c = 0; c < NC; c++) begin
        a = (BASE + c) % DEPTH;
        e.cyc = st + 2 * c; e.addr = AW'(a); e.data = '0;
        exp_r.push_back(e);
        e.cyc = st + 2 * c + 1;
        e.data = DW'((int'(ref_mem[a]) + int'(ps[c])) % (1 << DW));
        exp_w.push_back(e);
      end
      exp_done.push_back(st + 2 * NC);
      busy_lo = st; busy_hi = st + 2 * NC - 1;
    end
  endtask

  // Reset sampled at the next edge: nothing from cycle 'cut' on happens
  task automatic model_reset(input int cut);
    while (exp_w.size() > 0 && exp_w[exp_w.size()-1].cyc >= cut) void'(exp_w.pop_back());
    while (exp_r.size() > 0 && exp_r[exp_r.size()-1].cyc >= cut) void'(exp_r.pop_back());
    while (exp_done.size() > 0 && exp_done[exp_done.size()-1] >= cut) void'(exp_done.pop_back());
    if (busy_hi >= cut) busy_hi = cut - 1;
    ref_iter = 0;
  endtask

  // Per-cycle monitor against the model, sampled mid-cycle on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      mon_eb = (cnt >= busy_lo) && (cnt <= busy_hi);
      chk("busy", 32'(busy), 32'(mon_eb));
      chk("req_dropped", 32'(req_dropped), 32'(write_psum_ctrl & mon_eb));
      chk("rw_same_cycle", 32'(read_req & write_en), 32'd0);
      if (write_en) begin
        if (exp_w.size() == 0 || exp_w[0].cyc != cnt) begin
          chk("unexpected_write", 32'(write_en), 32'd0);
        end else begin
          chk("w_addr", 32'(w_addr), 32'(exp_w[0].addr));
          chk("w_data", 32'(w_data), 32'(exp_w[0].data));
          ref_mem[exp_w[0].addr] = exp_w[0].data;
          mon_e.cyc = cnt; mon_e.addr = w_addr; mon_e.data = w_data;
          obs.push_back(mon_e);
          void'(exp_w.pop_front());
        end
      end else begin
        chk("idle_w_addr", 32'(w_addr), 32'd0);
        chk("idle_w_data", 32'(w_data), 32'd0);
        if (exp_w.size() > 0 && exp_w[0].cyc <= cnt) begin
          chk("missing_write", 32'(write_en), 32'd1);
          void'(exp_w.pop_front());
        end
      end
      if (read_req) begin
        if (exp_r.size() == 0 || exp_r[0].cyc != cnt) begin
          chk("unexpected_read", 32'(read_req), 32'd0);
        end else begin
          chk("r_addr", 32'(r_addr), 32'(exp_r[0].addr));
          void'(exp_r.pop_front());
        end
      end else begin
        chk("idle_r_addr", 32'(r_addr), 32'd0);
        if (exp_r.size() > 0 && exp_r[0].cyc <= cnt) begin
          chk("missing_read", 32'(read_req), 32'd1);
          void'(exp_r.pop_front());
        end
      end
      mon_ed = (exp_done.size() > 0) && (exp_done[0] == cnt);
      chk("done", 32'(done), 32'(mon_ed));
      while (exp_done.size() > 0 && exp_done[0] <= cnt) void'(exp_done.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [NC-1:0][DW-1:0] rand_ps();
    logic [NC-1:0][DW-1:0] r;
    for (int c = 0; c < NC; c++) r[c] = DW'($urandom);
    return r;
  endfunction

  function automatic vec_t mk(input bit acc, input bit clr, input bit pre,
                              input int pv0, input int pv1, input int pv2,
                              input int p0, input int p1, input int p2,
                              input int a0, input int a1, input int a2,
                              input int d0, input int d1, input int d2);
    vec_t v;
    v.acc = acc; v.clr = clr; v.pre = pre;
    v.pre_v[0] = DW'(pv0); v.pre_v[1] = DW'(pv1); v.pre_v[2] = DW'(pv2);
    v.ps[0] = DW'(p0); v.ps[1] = DW'(p1); v.ps[2] = DW'(p2);
    v.ea[0] = AW'(a0); v.ea[1] = AW'(a1); v.ea[2] = AW'(a2);
    v.ed[0] = DW'(d0); v.ed[1] = DW'(d1); v.ed[2] = DW'(d2);
    return v;
  endfunction

  // Present a request for one cycle; afterwards scramble the column inputs
  task automatic issue(input bit acc, input logic [NC-1:0][DW-1:0] ps, output int rc);
    write_psum_ctrl = 1'b1;
    accum_en = acc;
    for (int c = 0; c < NC; c++) spad[c] = ps[c];
    rc = cnt;
    model_request(acc, ps);
    tick();
    write_psum_ctrl = 1'b0;
    accum_en = 1'($urandom);
    for (int c = 0; c < NC; c++) spad[c] = DW'($urandom);
  endtask

  // Wait (bounded) for done; optionally raise a request in cycle 2 of the drain
  task automatic wait_done(input bit inject, input int budget, output int dcyc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      write_psum_ctrl = 1'b0;
      if (inject && i == 0) begin
        write_psum_ctrl = 1'b1;
        accum_en = 1'($urandom);
        #1;
        chk("req_dropped_mid_drain", 32'(req_dropped), 32'd1);
      end
      if (done === 1'b1) found = 1'b1;
    end
    if (!found) chk("done_timeout", 32'(done), 32'd1);
    dcyc = cnt;
  endtask

  initial begin
    int rc;
    int dc;
    bit b2b;
    reset = 1'b0; write_psum_ctrl = 1'b1; accum_en = 1'b0; iter_clr = 1'b0;
    for (int c = 0; c < NC; c++) spad[c] = DW'($urandom);
    for (int i = 0; i < DEPTH; i++) begin
      glb[i] = DW'($urandom);
      ref_mem[i] = glb[i];
    end

    // Reset held with a request pending: every output is 0
    tick(); tick();
    mon_en = 1'b1;
    chk("rst_read_req", 32'(read_req), 32'd0);
    chk("rst_r_addr", 32'(r_addr), 32'd0);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_w_addr", 32'(w_addr), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req_dropped", 32'(req_dropped), 32'd0);
    reset = 1'b1; write_psum_ctrl = 1'b0;
    tick();

    //               acc clr pre  preload              psums                 addresses  data
    tbl[0] = mk(0, 0, 0, 0, 0, 0,            5, 7, 9,             0, 1, 2,   5, 7, 9);
    tbl[1] = mk(0, 1, 0, 0, 0, 0,            1, 2, 3,             0, 1, 2,   1, 2, 3);
    tbl[2] = mk(0, 0, 0, 0, 0, 0,            4, 5, 6,             3, 4, 5,   4, 5, 6);
    tbl[3] = mk(0, 0, 0, 0, 0, 0,            7, 8, 9,             6, 7, 8,   7, 8, 9);
    tbl[4] = mk(0, 0, 0, 0, 0, 0,            10, 11, 12,          0, 1, 2,   10, 11, 12);
    tbl[5] = mk(0, 0, 0, 0, 0, 0,            20, 21, 22,          3, 4, 5,   20, 21, 22);
    tbl[6] = mk(0, 1, 0, 0, 0, 0,            30, 31, 32,          0, 1, 2,   30, 31, 32);
    tbl[7] = mk(1, 0, 1, 100, 200, 300,      1, 2, 3,             0, 1, 2,   101, 202, 303);
    tbl[8] = mk(1, 0, 1, 'hFFFF, 'h8000, 0,  2, 'h8000, 'hFFFF,   0, 1, 2,   1, 0, 'hFFFF);
    tbl[9] = mk(0, 0, 0, 0, 0, 0,            40, 41, 42,          3, 4, 5,   40, 41, 42);

    for (int t = 0; t < 10; t++) begin
      if (tbl[t].clr) begin
        iter_clr = 1'b1; ref_iter = 0; tick(); iter_clr = 1'b0;
      end
      if (tbl[t].pre) begin
        for (int c = 0; c < NC; c++) begin
          glb[BASE + c] = tbl[t].pre_v[c];
          ref_mem[BASE + c] = tbl[t].pre_v[c];
        end
      end
      obs.delete();
      issue(tbl[t].acc, tbl[t].ps, rc);
      wait_done(1'b0, 4 * NC + 4, dc);
      chk("tbl_done_latency", 32'(dc - rc), tbl[t].acc ? 32'(2 * NC + 1) : 32'(NC + 1));
      chk("tbl_num_writes", 32'(obs.size()), 32'(NC));
      for (int c = 0; c < NC; c++) begin
        if (c < obs.size()) begin
          chk("tbl_addr", 32'(obs[c].addr), 32'(tbl[t].ea[c]));
          chk("tbl_data", 32'(obs[c].data), 32'(tbl[t].ed[c]));
          chk("tbl_write_cycle", 32'(obs[c].cyc - rc), tbl[t].acc ? 32'(2 * c + 2) : 32'(c + 1));
        end
      end
      tick(); tick();
    end

    // Request during a drain is dropped; request in the done cycle is accepted
    issue(1'b0, rand_ps(), rc);
    wait_done(1'b1, 4 * NC + 4, dc);
    chk("drop_done_latency", 32'(dc - rc), 32'(NC + 1));
    issue(1'b1, rand_ps(), rc);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_read_req", 32'(read_req), 32'd1);
    wait_done(1'b0, 4 * NC + 4, dc);
    chk("b2b_done_latency", 32'(dc - rc), 32'(2 * NC + 1));
    tick();

    // iter_clr coinciding with the end-of-pass advance: the clear wins
    iter_clr = 1'b1; ref_iter = 0; tick(); iter_clr = 1'b0;
    issue(1'b0, rand_ps(), rc);
    tick(); tick();
    iter_clr = 1'b1; ref_iter = 0;
    tick();
    iter_clr = 1'b0;
    chk("clr_pass_done", 32'(done), 32'd1);
    issue(1'b0, rand_ps(), rc);
    chk("clr_wins_addr", 32'(w_addr), 32'(BASE));
    wait_done(1'b0, 4 * NC + 4, dc);
    tick();

    // Reset in cycle 3 of an accumulate drain
    issue(1'b1, rand_ps(), rc);
    tick(); tick();
    chk("rst_mid_read_phase", 32'(read_req), 32'd1);
    reset = 1'b0;
    model_reset(cnt + 1);
    tick();
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_write_en", 32'(write_en), 32'd0);
    chk("rst_mid_read_req", 32'(read_req), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    issue(1'b0, rand_ps(), rc);
    wait_done(1'b0, 4 * NC + 4, dc);

    // Randomized passes
    b2b = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (!b2b) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          if ($urandom_range(0, 3) == 0) begin
            iter_clr = 1'b1; ref_iter = 0;
          end
          tick();
          iter_clr = 1'b0;
        end
      end
      issue(1'($urandom), rand_ps(), rc);
      wait_done($urandom_range(0, 2) == 0, 4 * NC + 4, dc);
      b2b = 1'($urandom);
    end
    tick(); tick(); tick();
    chk("leftover_writes", 32'(exp_w.size()), 32'd0);
    chk("leftover_reads", 32'(exp_r.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
